// File: rtl/apa102_in.sv
// APA102 stream receiver: decodes an external DATA/CLOCK pair into 32-bit
// LED frames and writes each pixel to SRAM as two 16-bit words.
//
//   state | meaning
//   HUNT  | counting consecutive zero bits, waiting for a start frame
//   PIXEL | assembling 32-bit LED frames after a start frame
module apa102_in #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES    = 4800
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         data_in,
  input  logic                         clock_in,
  input  logic [ADDRESS_BUS_WIDTH-1:0] start_address,
  input  logic [ADDRESS_BUS_WIDTH-1:0] word_limit,
  output logic [ADDRESS_BUS_WIDTH-1:0] write_address,
  output logic [15:0]                  write_data,
  output logic                         write_strobe,
  output logic                         frame_strobe,
  output logic                         error_strobe,
  output logic [ADDRESS_BUS_WIDTH-1:0] pixel_count,
  output logic                         overflow
);

  localparam int AW = ADDRESS_BUS_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   TWO_WORDS    = (AW+1)'(2);

  typedef enum logic {HUNT, PIXEL} state_t;

  state_t          state, state_next;
  logic            data_s1, data_s2;
  logic            clk_s1, clk_s2, clk_s3;
  logic [31:0]     shift_q;
  logic [4:0]      bit_count;
  logic [4:0]      zero_count;
  logic [TW-1:0]   timeout_cnt;
  logic [AW-1:0]   base_q, limit_q, words_written;
  logic            word1_pending;
  logic [15:0]     word1_data;

  logic            bit_valid, frame_done, timeout_hit;
  logic            start_det, pixel_ok, bad_frame, has_room, end_pulse;
  logic [31:0]     frame_next;
  logic [AW:0]     words_after;

  // Two-flop synchronizers plus a third clock stage for rising-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
      clk_s1  <= 1'b0;
      clk_s2  <= 1'b0;
      clk_s3  <= 1'b0;
    end else begin
      data_s1 <= data_in;
      data_s2 <= data_s1;
      clk_s1  <= clock_in;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
    end
  end

  // Frame-level event decode shared by the FSM and the datapath.
  always_comb begin
    bit_valid   = clk_s2 & ~clk_s3;
    frame_next  = {shift_q[30:0], data_s2};
    frame_done  = bit_valid && (state == PIXEL) && (bit_count == 5'd31);
    timeout_hit = !bit_valid && (timeout_cnt == TIMEOUT_LAST);
    start_det   = (bit_valid && (state == HUNT) && !data_s2 && (zero_count == 5'd31)) ||
                  (frame_done && (frame_next == 32'h0));
    pixel_ok    = frame_done && (frame_next[31:29] == 3'b111);
    bad_frame   = frame_done && (frame_next[31:29] != 3'b111) && (frame_next != 32'h0);
    words_after = {1'b0, words_written} + TWO_WORDS;
    has_room    = words_after <= {1'b0, limit_q};
    end_pulse   = (state == PIXEL) && (start_det || bad_frame || timeout_hit) &&
                  (pixel_count != '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      HUNT:    if (start_det) state_next = PIXEL;
      PIXEL:   if (bad_frame || timeout_hit) state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  // Bit assembly, counters, SRAM writes and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q       <= '0;
      bit_count     <= '0;
      zero_count    <= '0;
      timeout_cnt   <= '0;
      base_q        <= '0;
      limit_q       <= '0;
      words_written <= '0;
      word1_pending <= 1'b0;
      word1_data    <= '0;
      write_address <= '0;
      write_data    <= '0;
      write_strobe  <= 1'b0;
      frame_strobe  <= 1'b0;
      error_strobe  <= 1'b0;
      pixel_count   <= '0;
      overflow      <= 1'b0;
    end else begin
      write_strobe <= 1'b0;
      frame_strobe <= end_pulse;
      error_strobe <= bad_frame;

      if (bit_valid)                        timeout_cnt <= '0;
      else if (timeout_cnt != TIMEOUT_MAX)  timeout_cnt <= timeout_cnt + TW'(1);

      // Second word of the previous pixel; its address is derived from the
      // first, so a restart in this cycle cannot disturb it.
      if (word1_pending) begin
        write_strobe  <= 1'b1;
        write_address <= write_address + AW'(1);
        write_data    <= word1_data;
        word1_pending <= 1'b0;
      end

      if (state == HUNT) begin
        if (bit_valid) zero_count <= data_s2 ? 5'd0 : zero_count + 5'd1;
        else if (timeout_hit) zero_count <= '0;
      end else begin
        zero_count <= '0;
        if (bit_valid) begin
          shift_q   <= frame_next;
          bit_count <= bit_count + 5'd1;
        end
        if (timeout_hit) bit_count <= '0;
      end

      if (pixel_ok) begin
        if (has_room) begin
          write_strobe  <= 1'b1;
          write_address <= base_q + words_written;
          write_data    <= frame_next[31:16];
          word1_data    <= frame_next[15:0];
          word1_pending <= 1'b1;
          words_written <= words_after[AW-1:0];
        end else begin
          overflow <= 1'b1;
        end
        if (pixel_count != '1) pixel_count <= pixel_count + AW'(1);
      end

      if (start_det) begin
        base_q        <= start_address;
        limit_q       <= word_limit;
        pixel_count   <= '0;
        overflow      <= 1'b0;
        words_written <= '0;
        bit_count     <= '0;
        zero_count    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apa102_in.sv
// Bench for apa102_in: drives bit-level APA102 traffic, predicts writes and
// strobes with a frame-level model, and pins the model with literal values.
module tb_apa102_in;
  localparam int AW = 16;
  localparam int TO = 4800;

  logic          clk = 1'b0;
  logic          rst, data_in, clock_in;
  logic [AW-1:0] start_address, word_limit;
  logic [AW-1:0] write_address, pixel_count;
  logic [15:0]   write_data;
  logic          write_strobe, frame_strobe, error_strobe, overflow;

  apa102_in #(.ADDRESS_BUS_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .clock_in(clock_in),
    .start_address(start_address), .word_limit(word_limit),
    .write_address(write_address), .write_data(write_data),
    .write_strobe(write_strobe), .frame_strobe(frame_strobe),
    .error_strobe(error_strobe), .pixel_count(pixel_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  bit          m_hunt;
  int          m_zero, m_n;
  logic [31:0] m_acc;
  logic [15:0] m_base, m_limit, m_words, m_pix;
  logic        m_ovf;
  int          exp_frames = 0, exp_errors = 0;
  logic [15:0] exp_addr[$], exp_data[$];
  bit          exp_second[$];

  // observed
  int          act_frames = 0, act_errors = 0;
  logic [15:0] log_addr[$], log_data[$];
  int          cyc = 0, last_wr_cyc = -10;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hunt = 1; m_zero = 0; m_n = 0; m_acc = '0;
    m_base = '0; m_limit = '0; m_words = '0; m_pix = '0; m_ovf = 0;
    exp_addr.delete(); exp_data.delete(); exp_second.delete();
  endtask

  task automatic model_start();
    m_hunt = 0; m_zero = 0; m_n = 0;
    m_base = start_address; m_limit = word_limit;
    m_pix = '0; m_ovf = 0; m_words = '0;
  endtask

  task automatic model_frame(input logic [31:0] f);
    logic [15:0] a;
    if (f[31:29] == 3'b111) begin
      if (int'(m_words) + 2 <= int'(m_limit)) begin
        a = m_base + m_words;
        exp_addr.push_back(a); exp_data.push_back(f[31:16]); exp_second.push_back(0);
        a = a + 16'd1;
        exp_addr.push_back(a); exp_data.push_back(f[15:0]); exp_second.push_back(1);
        m_words = m_words + 16'd2;
      end else begin
        m_ovf = 1;
      end
      if (m_pix != 16'hFFFF) m_pix = m_pix + 16'd1;
    end else if (f == 32'h0) begin
      if (m_pix != 0) exp_frames++;
      model_start();
    end else begin
      exp_errors++;
      if (m_pix != 0) exp_frames++;
      m_hunt = 1; m_zero = 0;
    end
  endtask

  task automatic model_bit(input logic b);
    if (m_hunt) begin
      if (!b) begin
        m_zero++;
        if (m_zero == 32) model_start();
      end else m_zero = 0;
    end else begin
      m_acc = {m_acc[30:0], b};
      m_n++;
      if (m_n == 32) begin
        m_n = 0;
        model_frame(m_acc);
      end
    end
  endtask

  task automatic model_timeout();
    if (!m_hunt) begin
      if (m_pix != 0) exp_frames++;
      m_hunt = 1; m_n = 0; m_zero = 0;
    end else m_zero = 0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits);
    for (int i = 31; i > 31 - nbits; i--) begin
      model_bit(w[i]);
      data_in = w[i];
      clock_in = 1'b1;
      repeat (4) @(negedge clk);
      clock_in = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_bits(w, 32);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    if (n > TO + 10) model_timeout();
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pixel_count"}, pixel_count, m_pix);
    check({tag, "_overflow"}, overflow, m_ovf);
    check({tag, "_frames"}, act_frames, exp_frames);
    check({tag, "_errors"}, act_errors, exp_errors);
    check({tag, "_pending_writes"}, exp_addr.size(), 0);
  endtask

  always @(posedge clk) cyc++;

  // compare process: every write must match the next predicted write
  always @(negedge clk) begin
    if (frame_strobe) act_frames++;
    if (error_strobe) act_errors++;
    if (write_strobe) begin
      log_addr.push_back(write_address);
      log_data.push_back(write_data);
      checks++;
      if (exp_addr.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr %h data %h, no write expected", write_address, write_data);
      end else begin
        logic [15:0] ea, ed;
        bit es;
        ea = exp_addr.pop_front(); ed = exp_data.pop_front(); es = exp_second.pop_front();
        if (write_address !== ea || write_data !== ed || (es && cyc != last_wr_cyc + 1)) begin
          errors++;
          $display("FAIL write_match: got addr %h data %h at cycle %0d, expected addr %h data %h%s",
                   write_address, write_data, cyc, ea, ed, es ? " on next cycle" : "");
        end
      end
      last_wr_cyc = cyc;
    end
  end

  initial begin
    rst = 1; data_in = 0; clock_in = 0; start_address = '0; word_limit = '0;
    model_reset();
    repeat (4) @(negedge clk);
    check("reset_write_strobe", write_strobe, 0);
    check("reset_pixel_count", pixel_count, 0);
    check("reset_overflow", overflow, 0);
    check("reset_write_address", write_address, 0);
    rst = 0;

    // single pixel then timeout
    start_address = 16'h0100; word_limit = 16'h0040; log_addr.delete(); log_data.delete();
    send_word(32'h0); send_word(32'hE1102030); idle(5000);
    check_model("t1");
    check("t1_nwrites", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("t1_addr0", log_addr[0], 16'h0100); check("t1_data0", log_data[0], 16'hE110);
      check("t1_addr1", log_addr[1], 16'h0101); check("t1_data1", log_data[1], 16'h2030);
    end
    check("t1_frames_lit", act_frames, 1);
    check("t1_pix_lit", pixel_count, 1);

    // word_limit overflow
    start_address = 16'h0010; word_limit = 16'h0004; log_addr.delete(); log_data.delete();
    send_word(32'h0); send_word(32'hE0000001); send_word(32'hE0000002); send_word(32'hFFFFFFFF);
    idle(20);
    check("t2_ovf_lit", overflow, 1);
    idle(5000);
    check_model("t2");
    check("t2_nwrites", log_addr.size(), 4);
    if (log_addr.size() == 4) check("t2_addr3", log_addr[3], 16'h0013);
    check("t2_pix_lit", pixel_count, 3);
    check("t2_frames_lit", act_frames, 2);

    // restart inside a frame
    start_address = 16'h0020; word_limit = 16'h0040; log_addr.delete(); log_data.delete();
    send_word(32'h0); send_word(32'hE0000011); send_word(32'hE0000022);
    start_address = 16'h0200;
    send_word(32'h0);
    idle(10);
    check("t3_frames_after_restart", act_frames, 3);
    send_word(32'hE1234567); idle(5000);
    check_model("t3");
    check("t3_nwrites", log_addr.size(), 6);
    if (log_addr.size() == 6) begin
      check("t3_addr4", log_addr[4], 16'h0200); check("t3_data4", log_data[4], 16'hE123);
      check("t3_addr5", log_addr[5], 16'h0201); check("t3_data5", log_data[5], 16'h4567);
    end
    check("t3_pix_lit", pixel_count, 1);

    // malformed frame then recovery
    start_address = 16'h0050; log_addr.delete(); log_data.delete();
    send_word(32'h0); send_word(32'h40000000); idle(10);
    check("t4_error_lit", act_errors, 1);
    check("t4_nwrites_err", log_addr.size(), 0);
    send_word(32'h0); send_word(32'hF0F0AAAA); idle(5000);
    check_model("t4");
    check("t4_nwrites", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("t4_addr0", log_addr[0], 16'h0050); check("t4_data1", log_data[1], 16'hAAAA);
    end
    check("t4_frames_lit", act_frames, 5);

    // reset mid-pixel
    start_address = 16'h0070; log_addr.delete(); log_data.delete();
    send_word(32'h0); send_bits(32'hE9998888, 16);
    rst = 1; repeat (3) @(negedge clk); rst = 0;
    model_reset();
    check("t5_nwrites_reset", log_addr.size(), 0);
    check("t5_pix_after_reset", pixel_count, 0);
    start_address = 16'h0300;
    send_word(32'h0); send_word(32'hE5556666); idle(5000);
    check_model("t5");
    check("t5_nwrites", log_addr.size(), 2);
    if (log_addr.size() == 2) check("t5_addr0", log_addr[0], 16'h0300);
    check("t5_frames_lit", act_frames, 6);

    // address wrap
    start_address = 16'hFFFF; word_limit = 16'h0040; log_addr.delete(); log_data.delete();
    send_word(32'h0); send_word(32'hE7778888); idle(5000);
    check_model("t6");
    check("t6_nwrites", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("t6_addr0", log_addr[0], 16'hFFFF); check("t6_addr1", log_addr[1], 16'h0000);
      check("t6_data1", log_data[1], 16'h8888);
    end
    check("t6_frames_lit", act_frames, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
